// File: rtl/uart_pkg.sv
// Shared definitions for uart_param_transceiver.
//   uart_state_e : state encoding used by both the TX and the RX FSM.
//   frame_len    : clk cycles in one frame (start + data + parity + stop bits).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned has_parity,
                                            input int unsigned stop_bits,
                                            input int unsigned clks_per_bit);
    return (1 + data_width + has_parity + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_param_transceiver_if.sv
// Byte-side bus of uart_param_transceiver.
//   enable/i_data          : TX request and payload (master -> slave)
//   o_busy                 : TX frame in progress (slave -> master)
//   received_data          : last good RX payload (slave -> master)
//   data_is_valid/rx_error : 1-cycle RX result pulses (slave -> master)
interface uart_param_transceiver_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  enable;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_busy;
  logic [DATA_WIDTH-1:0] received_data;
  logic                  data_is_valid;
  logic                  rx_error;

  modport master (
    output enable, i_data,
    input  o_busy, received_data, data_is_valid, rx_error
  );

  modport slave (
    input  enable, i_data,
    output o_busy, received_data, data_is_valid, rx_error
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit timer shared by the TX and RX paths.
//   clk, reset : clock, synchronous active-high reset
//   start      : reload the counter to 0 on the next edge
//   half       : 1 = tick at the mid-bit point, 0 = tick at the end of the bit
//   tick       : timing point reached this cycle
// Counter wraps to 0 after CLKS_PER_BIT-1.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic half,
  output logic tick
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (start || (cnt_q == LAST)) cnt_d = '0;
    tick = (cnt_q == (half ? MID : LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_param_transceiver.sv
// Parametrised full-duplex UART (TX serialiser + RX deserialiser, one clock).
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : enable, i_data, o_busy, received_data, data_is_valid, rx_error
//   loopback_en  : 1 = RX fed from serial_out, serial_in ignored
//   serial_out   : TX line, idle high (registered)
//   serial_in    : RX line, asynchronous
// Optional feature: define UART_PARITY_EN to add a parity bit after the data.
module uart_param_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_param_transceiver_if.slave  bus,
  input  logic                     loopback_en,
  output logic                     serial_out,
  input  logic                     serial_in
);
`ifdef UART_PARITY_EN
  localparam logic HAS_PARITY = 1'b1;
`else
  localparam logic HAS_PARITY = 1'b0;
`endif
  localparam logic PAR_INV = (PARITY_ODD != 0);
  localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  // ---------------- TX ----------------
  uart_state_e           tx_state_d, tx_state_q;
  logic [DATA_WIDTH-1:0] tx_shift_d, tx_shift_q;
  logic [IW-1:0]         tx_idx_d, tx_idx_q;
  logic                  tx_par_d, tx_par_q;
  logic                  tx_line_d, tx_line_q;
  logic                  tx_start, tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .half  (1'b0),
    .tick  (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_par_d   = tx_par_q;
    tx_start   = 1'b0;
    case (tx_state_q)
      ST_IDLE: if (bus.enable) begin
        tx_shift_d = bus.i_data;
        tx_par_d   = (^bus.i_data) ^ PAR_INV;
        tx_state_d = ST_START;
        tx_start   = 1'b1;
      end
      ST_START: if (tx_tick) begin
        tx_state_d = ST_DATA;
        tx_idx_d   = '0;
      end
      ST_DATA: if (tx_tick) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_idx_q == LAST_DATA) begin
          tx_idx_d   = '0;
          tx_state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
        end else begin
          tx_idx_d = tx_idx_q + IW'(1);
        end
      end
      ST_PARITY: if (tx_tick) begin
        tx_state_d = ST_STOP;
        tx_idx_d   = '0;
      end
      ST_STOP: if (tx_tick) begin
        if (tx_idx_q == LAST_STOP) tx_state_d = ST_IDLE;
        else                       tx_idx_d   = tx_idx_q + IW'(1);
      end
      default: tx_state_d = ST_IDLE;
    endcase

    // Line level decoded from the next state so serial_out leaves a flop.
    case (tx_state_d)
      ST_START:  tx_line_d = 1'b0;
      ST_DATA:   tx_line_d = tx_shift_d[0];
      ST_PARITY: tx_line_d = tx_par_d;
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign serial_out = tx_line_q;
  assign bus.o_busy = (tx_state_q != ST_IDLE);

  // ---------------- RX ----------------
  // sync_q[1] is the synchronised line, sync_q[2] its previous value.
  logic [2:0]            sync_d, sync_q;
  logic                  rx_bit, rx_prev;
  uart_state_e           rx_state_d, rx_state_q;
  logic [DATA_WIDTH-1:0] rx_shift_d, rx_shift_q;
  logic [DATA_WIDTH-1:0] rx_data_d, rx_data_q;
  logic [IW-1:0]         rx_idx_d, rx_idx_q;
  logic                  rx_par_d, rx_par_q;
  logic                  stop_err_d, stop_err_q;
  logic                  valid_d, valid_q;
  logic                  err_d, err_q;
  logic                  rx_start, rx_half, rx_tick, par_bad;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (clk),
    .reset (reset),
    .start (rx_start),
    .half  (rx_half),
    .tick  (rx_tick)
  );

  always_comb begin
    sync_d  = {sync_q[1:0], (loopback_en ? serial_out : serial_in)};
    rx_bit  = sync_q[1];
    rx_prev = sync_q[2];
    par_bad = HAS_PARITY && (((^rx_shift_q) ^ PAR_INV) != rx_par_q);

    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_idx_d   = rx_idx_q;
    rx_par_d   = rx_par_q;
    stop_err_d = stop_err_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    rx_start   = 1'b0;
    rx_half    = (rx_state_q == ST_START);

    case (rx_state_q)
      // Edge detect (not level) so a held-low break cannot retrigger.
      ST_IDLE: if (rx_prev && !rx_bit) begin
        rx_state_d = ST_START;
        rx_start   = 1'b1;
      end
      // Mid-start sample; the timer is re-aligned so later ticks land mid-bit.
      ST_START: if (rx_tick) begin
        rx_start = 1'b1;
        if (!rx_bit) begin
          rx_state_d = ST_DATA;
          rx_idx_d   = '0;
          stop_err_d = 1'b0;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_DATA: if (rx_tick) begin
        rx_shift_d = {rx_bit, rx_shift_q[DATA_WIDTH-1:1]};
        if (rx_idx_q == LAST_DATA) begin
          rx_idx_d   = '0;
          rx_state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
        end else begin
          rx_idx_d = rx_idx_q + IW'(1);
        end
      end
      ST_PARITY: if (rx_tick) begin
        rx_par_d   = rx_bit;
        rx_idx_d   = '0;
        rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_tick) begin
        if (rx_idx_q == LAST_STOP) begin
          rx_state_d = ST_IDLE;
          if (stop_err_q || !rx_bit || par_bad) begin
            err_d = 1'b1;
          end else begin
            valid_d   = 1'b1;
            rx_data_d = rx_shift_q;
          end
        end else begin
          stop_err_d = stop_err_q | !rx_bit;
          rx_idx_d   = rx_idx_q + IW'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_idx_q   <= '0;
      rx_par_q   <= 1'b0;
      stop_err_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_idx_q   <= rx_idx_d;
      rx_par_q   <= rx_par_d;
      stop_err_q <= stop_err_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.received_data = rx_data_q;
  assign bus.data_is_valid = valid_q;
  assign bus.rx_error      = err_q;
endmodule

// File: tb/tb_uart_param_transceiver.sv
// Directed self-checking bench for uart_param_transceiver (DATA_WIDTH=8,
// CLKS_PER_BIT=4, STOP_BITS=1). Expected RX payloads go into a scoreboard
// queue when a frame is launched and are popped on data_is_valid.
module tb_uart_param_transceiver;
  import uart_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned CPB  = 4;
  localparam int unsigned STB  = 1;
  localparam int unsigned PODD = 0;
`ifdef UART_PARITY_EN
  localparam int unsigned HAS_PAR = 1;
`else
  localparam int unsigned HAS_PAR = 0;
`endif
  localparam int unsigned NBITS = 1 + DW + HAS_PAR + STB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loopback_en = 1'b0;
  logic serial_in = 1'b1;
  logic serial_out;

  uart_param_transceiver_if #(.DATA_WIDTH(DW)) bus ();

  uart_param_transceiver #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (STB),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .loopback_en (loopback_en),
    .serial_out  (serial_out),
    .serial_in   (serial_in)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned err_seen = 0;
  int unsigned exp_err = 0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial frame image, bit 0 = start bit.
  function automatic logic [31:0] mk_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    logic [31:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < int'(DW); i++) f[1+i] = d[i];
    if (HAS_PAR != 0) f[1+DW] = par;
    for (int s = 0; s < int'(STB); s++) f[1+DW+HAS_PAR+s] = stop;
    return f;
  endfunction

  task automatic drive_frame(input logic [31:0] f);
    for (int b = 0; b < int'(NBITS); b++) begin
      serial_in = f[b];
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  task automatic wait_sb_empty(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.data_is_valid || bus.rx_error) begin
        total++;
        assert (!(bus.data_is_valid && bus.rx_error)) else begin
          bad++;
          $error("FAIL pulse_excl observed=1 expected=0");
        end
      end
      if (bus.data_is_valid) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_valid observed=%0h expected=none", bus.received_data);
        end
        if (sb.size() != 0) begin
          logic [DW-1:0] e;
          e = sb.pop_front();
          total++;
          assert (bus.received_data === e) else begin
            bad++;
            $error("FAIL rx_data observed=%0h expected=%0h", bus.received_data, e);
          end
        end
      end
      if (bus.rx_error) err_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    int busy_cnt;
    bus.enable = 1'b0;
    bus.i_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_serial_out", serial_out, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_rdata", bus.received_data, 0);
    chk("rst_valid", bus.data_is_valid, 0);
    chk("rst_err", bus.rx_error, 0);
    reset = 1'b0;
    @(negedge clk);

    // Loopback 0xA5: line waveform, busy length, received value
    loopback_en = 1'b1;
    repeat (4) @(negedge clk);
    f = mk_frame(8'hA5, (^8'hA5) ^ PODD[0], 1'b1);
    bus.enable = 1'b1; bus.i_data = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    bus.enable = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < int'(NBITS * CPB); c++) begin
      chk("a5_line", serial_out, f[c / int'(CPB)]);
      if (bus.o_busy) busy_cnt++;
      @(negedge clk);
    end
    chk("a5_busy_len", busy_cnt, frame_len(DW, HAS_PAR, STB, CPB));
    chk("a5_busy_fall", bus.o_busy, 0);
    wait_sb_empty("a5_valid", 6);
    chk("a5_rdata", bus.received_data, 8'hA5);
    chk("a5_no_err", err_seen, exp_err);

    // Back-to-back 0x00 then 0xFF; enable while busy is ignored
    repeat (8) @(negedge clk);
    bus.enable = 1'b1; bus.i_data = 8'h00; sb.push_back(8'h00);
    @(negedge clk);
    bus.i_data = 8'h33;
    @(negedge clk);
    bus.enable = 1'b0;
    for (int i = 0; i < 200 && bus.o_busy; i++) @(negedge clk);
    chk("b2b_idle", bus.o_busy, 0);
    bus.enable = 1'b1; bus.i_data = 8'hFF; sb.push_back(8'hFF);
    @(negedge clk);
    bus.enable = 1'b0;
    chk("b2b_busy", bus.o_busy, 1);
    chk("b2b_start", serial_out, 0);
    wait_sb_empty("b2b_valid", 100);
    repeat (8) @(negedge clk);
    chk("b2b_rdata", bus.received_data, 8'hFF);
    chk("b2b_no_err", err_seen, exp_err);

    // Framing error: 0x3C with stop bit 0
    loopback_en = 1'b0;
    repeat (4) @(negedge clk);
    drive_frame(mk_frame(8'h3C, (^8'h3C) ^ PODD[0], 1'b0));
    exp_err++;
    repeat (10) @(negedge clk);
    chk("ferr_err", err_seen, exp_err);
    chk("ferr_rdata_held", bus.received_data, 8'hFF);

    // One-cycle low glitch while idle, then a good 0x5A
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_no_err", err_seen, exp_err);
    chk("glitch_rdata", bus.received_data, 8'hFF);
    sb.push_back(8'h5A);
    drive_frame(mk_frame(8'h5A, (^8'h5A) ^ PODD[0], 1'b1));
    wait_sb_empty("post_glitch_valid", 20);
    chk("post_glitch_rdata", bus.received_data, 8'h5A);

`ifdef UART_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    repeat (4) @(negedge clk);
    drive_frame(mk_frame(8'h07, 1'b0, 1'b1));
    exp_err++;
    repeat (10) @(negedge clk);
    chk("par_bad_err", err_seen, exp_err);
    chk("par_bad_rdata", bus.received_data, 8'h5A);
    sb.push_back(8'h07);
    drive_frame(mk_frame(8'h07, 1'b1, 1'b1));
    wait_sb_empty("par_ok_valid", 20);
    chk("par_ok_rdata", bus.received_data, 8'h07);
`endif

    // Reset mid-frame at cycle 17 of a loopback frame
    loopback_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1; bus.i_data = 8'h81;
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_busy", bus.o_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_serial_out", serial_out, 1);
    chk("mid_rst_busy", bus.o_busy, 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_no_err", err_seen, exp_err);
    chk("post_rst_rdata", bus.received_data, 0);
    chk("post_rst_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
